// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_perf_cnt.sv
// Fetch/squash event counters, instantiated only when IFETCH_PERF_EN is defined.
module ifetch_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_evt,
  input  logic        squash_evt,
  output logic [31:0] fetch_cnt,
  output logic [31:0] squash_cnt
);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetch_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      if (fetch_evt)  fetch_cnt  <= fetch_cnt + 32'd1;
      if (squash_evt) squash_cnt <= squash_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC owner, single-outstanding imem fetch, redirect squash.
// Optional perf counters are enabled by defining IFETCH_PERF_EN.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  input  logic        ready_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] squash_cnt_o
`endif
);

  state_t      state;
  logic [31:0] pc_q;
  logic        squash;
  logic        redirect;
  logic [31:0] redirect_pc;

  assign redirect    = jump_i | branch_i;
  assign redirect_pc = align_word(jump_i ? jump_target_i : branch_target_i);

  assign imem_req_o  = (state == ISSUE);
  assign imem_addr_o = pc_q;
  assign pc_plus4_o  = pc_o + PC_INC;

  // NOTE: all state is updated with non-blocking assignments so every branch
  // of the case statement sees the pre-edge values of pc_q, squash and state.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= ISSUE;
      pc_q    <= RESET_PC;
      squash  <= 1'b0;
      valid_o <= 1'b0;
      instr_o <= '0;
      pc_o    <= RESET_PC;
    end else begin
      case (state)
        ISSUE: begin
          state <= WAIT;
          if (redirect) begin
            pc_q   <= redirect_pc;
            squash <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            if (redirect) pc_q <= redirect_pc;
            // A stale or freshly redirected response is dropped and the
            // fetch is reissued from the (possibly new) pc_q.
            if (redirect || squash) begin
              squash <= 1'b0;
              state  <= ISSUE;
            end else begin
              instr_o <= imem_rdata_i;
              pc_o    <= pc_q;
              valid_o <= 1'b1;
              state   <= HOLD;
            end
          end else if (redirect) begin
            pc_q   <= redirect_pc;
            squash <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_q    <= redirect_pc;
            valid_o <= 1'b0;
            state   <= ISSUE;
          end else if (ready_i) begin
            pc_q    <= pc_q + PC_INC;
            valid_o <= 1'b0;
            state   <= ISSUE;
          end
        end
        default: state <= ISSUE;
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  logic fetch_evt;
  logic squash_evt;

  assign fetch_evt  = (state == HOLD) && valid_o && ready_i && !redirect;
  assign squash_evt = (state == WAIT) && imem_rvalid_i && (squash || redirect);

  ifetch_perf_cnt u_perf_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .fetch_evt  (fetch_evt),
    .squash_evt (squash_evt),
    .fetch_cnt  (fetch_cnt_o),
    .squash_cnt (squash_cnt_o)
  );
`endif

endmodule
